// File: rtl/pawn_move_gen_if.sv
// Shared board/piece types and the request/move-stream interface of the
// pawn move generator.

package pawn_pkg;
    typedef enum logic {WHITE = 1'b0, BLACK = 1'b1} color_t;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    typedef struct packed {
        color_t color;
        piece_t piece;
    } fullpiece_t;

    typedef fullpiece_t [63:0] board_t;
endpackage

interface pawn_move_gen_if #(parameter int CNT_W = 9);
    logic                start;
    pawn_pkg::color_t    side;
    pawn_pkg::board_t    board;
    logic                busy;
    logic                mv_valid;
    logic                mv_ready;
    logic [5:0]          mv_from;
    logic [5:0]          mv_to;
    logic                mv_capture;
    logic                mv_promote;
    logic                done;
    logic [CNT_W-1:0]    move_count;

    // generator side
    modport master (
        input  start, side, board, mv_ready,
        output busy, mv_valid, mv_from, mv_to, mv_capture, mv_promote,
               done, move_count
    );

    // requester / move-list side
    modport slave (
        output start, side, board, mv_ready,
        input  busy, mv_valid, mv_from, mv_to, mv_capture, mv_promote,
               done, move_count
    );
endinterface

// File: rtl/pawn_move_gen.sv
// Pawn move generator: snapshots the board on start, walks squares 0..63 one
// per cycle, and streams each pseudo-legal push/capture of the chosen side.
// Index layout is {row, col}; pawns advance along the column axis.

module pawn_move_gen
    import pawn_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic clk,
    input  logic rst_n,
    pawn_move_gen_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

    state_t           state, state_n;
    board_t           snap;
    color_t           side_q, side_n;
    logic [5:0]       sq, sq_n;
    logic [3:0]       mask, mask_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             load;

    logic [2:0]       row, col, col1, col2, last_col, start_col, tcol;
    fullpiece_t       pc, t1, t2, tl, tr;
    logic             own;
    logic [3:0]       cand, sel;
    logic [5:0]       to_idx;
    logic             emit;

    // Candidate mask for the square under the scan pointer. Neighbour indices
    // may wrap arithmetically, but every such candidate is gated off by the
    // last-column / edge-row terms, so no off-board target ever escapes.
    always_comb begin
        row       = sq[5:3];
        col       = sq[2:0];
        pc        = snap[sq];
        last_col  = (side_q == BLACK) ? 3'd0 : 3'd7;
        start_col = (side_q == BLACK) ? 3'd6 : 3'd1;
        col1      = (side_q == BLACK) ? col - 3'd1 : col + 3'd1;
        col2      = (side_q == BLACK) ? col - 3'd2 : col + 3'd2;
        t1        = snap[{row, col1}];
        t2        = snap[{row, col2}];
        tl        = snap[{row - 3'd1, col1}];
        tr        = snap[{row + 3'd1, col1}];
        own       = (pc.piece == PAWN) && (pc.color == side_q) && (col != last_col);
        cand[0]   = own && (t1.piece == EMPTY);
        cand[1]   = own && (col == start_col) && (t1.piece == EMPTY) && (t2.piece == EMPTY);
        cand[2]   = own && (row != 3'd0) && (tl.piece != EMPTY) && (tl.color != side_q);
        cand[3]   = own && (row != 3'd7) && (tr.piece != EMPTY) && (tr.color != side_q);
    end

    // Present the lowest pending candidate; outputs read zero outside EMIT and
    // only depend on held registers, so they stay frozen while stalled.
    always_comb begin
        sel    = mask & (~mask + 4'd1);
        to_idx = {row, col1};
        tcol   = col1;
        if (sel[1]) begin
            to_idx = {row, col2};
            tcol   = col2;
        end else if (sel[2]) begin
            to_idx = {row - 3'd1, col1};
        end else if (sel[3]) begin
            to_idx = {row + 3'd1, col1};
        end
        emit           = (state == S_EMIT);
        bus.mv_valid   = emit;
        bus.mv_from    = emit ? sq : 6'd0;
        bus.mv_to      = emit ? to_idx : 6'd0;
        bus.mv_capture = emit && (sel[2] || sel[3]);
        bus.mv_promote = emit && (tcol == last_col);
        bus.busy       = (state != S_IDLE);
        bus.done       = (state == S_DONE);
        bus.move_count = cnt;
    end

    // Next-state and datapath update decisions.
    always_comb begin
        state_n = state;
        sq_n    = sq;
        mask_n  = mask;
        cnt_n   = cnt;
        side_n  = side_q;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    side_n  = bus.side;
                    sq_n    = 6'd0;
                    mask_n  = 4'd0;
                    cnt_n   = '0;
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cand != 4'd0) begin
                    mask_n  = cand;
                    state_n = S_EMIT;
                end else if (sq == 6'd63) begin
                    state_n = S_DONE;
                end else begin
                    sq_n = sq + 6'd1;
                end
            end
            S_EMIT: begin
                if (bus.mv_ready) begin
                    mask_n = mask & ~sel;
                    if (cnt != '1) cnt_n = cnt + 1'b1;
                    if ((mask & ~sel) == 4'd0) begin
                        if (sq == 6'd63) begin
                            state_n = S_DONE;
                        end else begin
                            sq_n    = sq + 6'd1;
                            state_n = S_SCAN;
                        end
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Scan pointer, pending mask, side and move counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq     <= 6'd0;
            mask   <= 4'd0;
            cnt    <= '0;
            side_q <= WHITE;
        end else begin
            sq     <= sq_n;
            mask   <= mask_n;
            cnt    <= cnt_n;
            side_q <= side_n;
        end
    end

    // Board snapshot, frozen for the whole scan.
    always_ff @(posedge clk) begin
        if (load) snap <= bus.board;
    end

endmodule

// File: tb/tb_pawn_move_gen.sv
// Self-checking bench for pawn_move_gen: an in-bench move-list model built
// from board/side with integer geometry, a per-cycle stream monitor, directed
// cases with hand-derived expectations, then randomized boards and back-pressure.

module tb_pawn_move_gen;
    import pawn_pkg::*;

    localparam int CNT_W = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pawn_move_gen_if #(.CNT_W(CNT_W)) bus();

    pawn_move_gen #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int from;
        int to;
        bit cap;
        bit prom;
    } mv_t;

    mv_t exp_q[$];
    int  exp_n = 0;
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    bit  rand_ready = 1'b0;
    bit  fixed_ready = 1'b1;

    task automatic chk(input string nm, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference move list straight from the movement rules.
    task automatic build_exp(input board_t b, input color_t s);
        int f, lastc, startc, r, c, c1, c2, rr;
        exp_q.delete();
        f      = (s == BLACK) ? -1 : 1;
        lastc  = (s == BLACK) ? 0 : 7;
        startc = (s == BLACK) ? 6 : 1;
        for (int q = 0; q < 64; q++) begin
            r = q / 8;
            c = q % 8;
            if (b[q].piece == PAWN && b[q].color == s && c != lastc) begin
                c1 = c + f;
                c2 = c + 2 * f;
                if (b[r*8+c1].piece == EMPTY) begin
                    exp_q.push_back('{q, r*8+c1, 1'b0, c1 == lastc});
                    if (c == startc && b[r*8+c2].piece == EMPTY)
                        exp_q.push_back('{q, r*8+c2, 1'b0, c2 == lastc});
                end
                for (int dr = -1; dr <= 1; dr += 2) begin
                    rr = r + dr;
                    if (rr >= 0 && rr <= 7) begin
                        if (b[rr*8+c1].piece != EMPTY && b[rr*8+c1].color != s)
                            exp_q.push_back('{q, rr*8+c1, 1'b1, c1 == lastc});
                    end
                end
            end
        end
        exp_n = exp_q.size();
    endtask

    function automatic board_t rnd_board();
        board_t b;
        for (int q = 0; q < 64; q++) begin
            b[q].color = color_t'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    b[q].piece = EMPTY;
                2:       b[q].piece = PAWN;
                default: b[q].piece = piece_t'($urandom_range(1, 6));
            endcase
        end
        return b;
    endfunction

    // Consumer ready: random back-pressure or a fixed level.
    initial forever begin
        @(posedge clk);
        #1;
        bus.mv_ready = rand_ready ? ($urandom_range(0, 9) < 7) : fixed_ready;
    end

    // Stream monitor: every presented move against the model head, stall
    // stability, and the end-of-scan count.
    logic [5:0] h_from, h_to;
    logic       h_cap, h_prom;
    bit         stalled = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (bus.mv_valid) begin
                if (stalled) begin
                    chk("stall_from", bus.mv_from, h_from);
                    chk("stall_to", bus.mv_to, h_to);
                    chk("stall_flags", {bus.mv_capture, bus.mv_promote}, {h_cap, h_prom});
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_move: got %0d->%0d expected no move", bus.mv_from, bus.mv_to);
                end else begin
                    chk("mv_from", bus.mv_from, exp_q[0].from);
                    chk("mv_to", bus.mv_to, exp_q[0].to);
                    chk("mv_capture", bus.mv_capture, exp_q[0].cap);
                    chk("mv_promote", bus.mv_promote, exp_q[0].prom);
                end
                if (bus.mv_ready === 1'b1) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_from  = bus.mv_from;
                    h_to    = bus.mv_to;
                    h_cap   = bus.mv_capture;
                    h_prom  = bus.mv_promote;
                end
            end else if (stalled) begin
                chk("valid_dropped", bus.mv_valid, 1);
                stalled = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                chk("moves_left_at_done", exp_q.size(), 0);
                chk("move_count", bus.move_count, exp_n);
            end
        end
    end

    task automatic start_scan(input board_t b, input color_t s);
        bus.board = b;
        bus.side  = s;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.board = rnd_board();  // snapshot must ignore this
    endtask

    task automatic wait_done(input string nm);
        int old;
        bit seen;
        old  = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != old) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, seen, 1);
    endtask

    task automatic wait_valid(input string nm, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            n++;
            #2;
            if (bus.mv_valid) seen = 1'b1;
        end
        chk({nm, "_valid_seen"}, seen, 1);
    endtask

    board_t b1, b2, b3, b5, bl;
    int     n, busy_hi, old_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.side  = WHITE;
        bus.board = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.mv_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_from", bus.mv_from, 0);
        chk("rst_to", bus.mv_to, 0);
        chk("rst_capture", bus.mv_capture, 0);
        chk("rst_promote", bus.mv_promote, 0);
        chk("rst_count", bus.move_count, 0);
        rst_n = 1'b1;

        // 1: lone white pawn on its start column
        b1 = '0;
        b1[33] = '{WHITE, PAWN};
        build_exp(b1, WHITE);
        chk("t1_len", exp_q.size(), 2);
        chk("t1_m0_to", exp_q[0].to, 34);
        chk("t1_m1_to", exp_q[1].to, 35);
        start_scan(b1, WHITE);
        wait_done("t1");

        // 2: add two capturable black pieces
        b2 = b1;
        b2[26] = '{BLACK, KNIGHT};
        b2[42] = '{BLACK, PAWN};
        build_exp(b2, WHITE);
        chk("t2_len", exp_q.size(), 4);
        chk("t2_m2_to", exp_q[2].to, 26);
        chk("t2_m2_cap", exp_q[2].cap, 1);
        chk("t2_m3_to", exp_q[3].to, 42);
        start_scan(b2, WHITE);
        wait_done("t2");

        // 3: black pawn one step from promotion on the bottom row edge
        b3 = '0;
        b3[1] = '{BLACK, PAWN};
        b3[8] = '{WHITE, ROOK};
        build_exp(b3, BLACK);
        chk("t3_len", exp_q.size(), 2);
        chk("t3_m0_to", exp_q[0].to, 0);
        chk("t3_m0_prom", exp_q[0].prom, 1);
        chk("t3_m1_to", exp_q[1].to, 8);
        chk("t3_m1_capprom", {exp_q[1].cap, exp_q[1].prom}, 2'b11);
        start_scan(b3, BLACK);
        wait_done("t3");

        // first-move latency: pawn on square 0, valid one edge after acceptance
        bl = '0;
        bl[0] = '{WHITE, PAWN};
        build_exp(bl, WHITE);
        start_scan(bl, WHITE);
        wait_valid("lat", n);
        chk("first_valid_edges", n, 1);
        wait_done("lat");

        // 4: five-cycle stall on the first move of case 2
        fixed_ready = 1'b0;
        build_exp(b2, WHITE);
        start_scan(b2, WHITE);
        wait_valid("t4", n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #3;
            chk("t4_hold_valid", bus.mv_valid, 1);
            chk("t4_hold_from", bus.mv_from, 33);
            chk("t4_hold_to", bus.mv_to, 34);
        end
        fixed_ready = 1'b1;
        wait_done("t4");

        // 5: no white pawns; second start while busy is ignored
        b5 = '0;
        b5[20] = '{BLACK, PAWN};
        b5[33] = '{WHITE, KNIGHT};
        build_exp(b5, WHITE);
        chk("t5_len", exp_q.size(), 0);
        old_done  = done_cnt;
        bus.board = b5;
        bus.side  = WHITE;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);           // acceptance edge
        #1 bus.start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #2;
            if (bus.done) break;
            if (n == 10) bus.start = 1'b1;
            if (n == 11) bus.start = 1'b0;
        end
        // done occupies the 66th cycle when the start cycle counts as the 1st
        chk("t5_done_edges", n, 64);
        busy_hi = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            if (bus.busy || bus.done) busy_hi++;
        end
        chk("t5_idle_after_done", busy_hi, 0);
        chk("t5_single_done", done_cnt - old_done, 1);

        // 6: reset mid-EMIT, then a clean regeneration
        fixed_ready = 1'b0;
        build_exp(b2, WHITE);
        start_scan(b2, WHITE);
        wait_valid("t6", n);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", bus.mv_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_count", bus.move_count, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fixed_ready = 1'b1;
        build_exp(b2, WHITE);
        start_scan(b2, WHITE);
        wait_done("t6_rerun");

        // randomized boards, sides and back-pressure
        rand_ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            color_t s;
            board_t br;
            s  = color_t'($urandom_range(0, 1));
            br = rnd_board();
            build_exp(br, s);
            start_scan(br, s);
            wait_done("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
